move_sequencer: RTL

Two-axis move sequencer for the plotter motion path. It accepts one move command at a time over a valid/ready handshake, drives the per-axis direction lines and waits out a direction-settle interval. It then launches the X and Y pulse-generator channels together and reports completion once both channels finish. It sits between the command decoder and the two axis pulse generators, sharing their `clk_en` tick.

---
 rtl/move_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - two-axis move sequencer: direction settle, joint trigger, joint completion
module move_sequencer #(
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8,
  parameter int SETTLE_TICKS     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [PULSE_NUM_BITS-1:0]   cmd_x_num,
  input  logic [PULSE_NUM_BITS-1:0]   cmd_y_num,
  input  logic                        cmd_x_dir,
  input  logic                        cmd_y_dir,
  input  logic [PULSE_WIDTH_BITS-1:0] cmd_width,
  output logic [PULSE_NUM_BITS-1:0]   x_pulse_num,
  output logic [PULSE_NUM_BITS-1:0]   y_pulse_num,
  output logic [PULSE_WIDTH_BITS-1:0] x_pulse_width,
  output logic [PULSE_WIDTH_BITS-1:0] y_pulse_width,
  output logic                        x_trigger,
  output logic                        y_trigger,
  input  logic                        x_rdy,
  input  logic                        y_rdy,
  input  logic                        x_done,
  input  logic                        y_done,
  output logic                        x_dir,
  output logic                        y_dir,
  output logic                        busy,
  output logic                        move_done
);

  localparam int CNT_BITS = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    TRIGGER,
    GUARD,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_BITS-1:0] settle_cnt;
  logic                x_seen;
  logic                y_seen;
  logic                both_rdy;
  logic                dir_change;

  assign both_rdy   = x_rdy & y_rdy;
  assign dir_change = (cmd_x_dir != x_dir) || (cmd_y_dir != y_dir);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign move_done = (state == DONE);
  // Both triggers share one condition so the axes always launch on the same tick.
  assign x_trigger = (state == TRIGGER) & both_rdy;
  assign y_trigger = (state == TRIGGER) & both_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      x_seen        <= 1'b0;
      y_seen        <= 1'b0;
      x_dir         <= 1'b0;
      y_dir         <= 1'b0;
      x_pulse_num   <= '0;
      y_pulse_num   <= '0;
      x_pulse_width <= '0;
      y_pulse_width <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x_pulse_num   <= cmd_x_num;
            y_pulse_num   <= cmd_y_num;
            x_pulse_width <= cmd_width;
            y_pulse_width <= cmd_width;
            if (dir_change) begin
              x_dir      <= cmd_x_dir;
              y_dir      <= cmd_y_dir;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              state <= TRIGGER;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + CNT_BITS'(1);
          if (settle_cnt == SETTLE_LAST) state <= TRIGGER;
        end
        TRIGGER: begin
          if (both_rdy) begin
            x_seen <= 1'b0;
            y_seen <= 1'b0;
            state  <= GUARD;
          end
        end
        // Done levels left over from the previous move are still visible here.
        GUARD: state <= RUN;
        RUN: begin
          x_seen <= x_seen | x_done;
          y_seen <= y_seen | y_done;
          if ((x_seen | x_done) && (y_seen | y_done)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
